uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   UART transmitter. Serialises the byte the ALU/UART interface presents on tx_start/din
//   onto the serial line as 8N1 (or 8E1 with parity), LSB first, at the oversampled baud tick.
//   Sits downstream of the interface FSM; its tx_done_tick returns that FSM to receive_A.
// PARAMETERS
//   NBIT_DATA_LEN  8   data bits per frame
//   SB_TICK        16  s_tick count for the stop bit (16 = 1 stop bit, 32 = 2 stop bits)
//   OVERSAMPLE     16  s_tick count per start, data and parity bit
// PORTS
//   clk           in   1              system clock, all state on posedge
//   reset         in   1              asynchronous, active-high
//   s_tick        in   1              baud x OVERSAMPLE enable pulse, 1 clk wide
//   tx_start      in   1              level request; a frame starts on its rising edge only
//   din           in   NBIT_DATA_LEN  byte to send
//   tx            out  1              serial line, idle high
//   tx_done_tick  out  1              1-clk pulse at end of stop bit
//   busy          out  1              high from start acceptance until return to IDLE
// BEHAVIOUR
//   - Reset (async): state=IDLE, tx=1, tx_done_tick=0, busy=0, tick/bit counters=0,
//     shift reg=0, tx_start_q=0. Asserting reset mid-frame aborts the frame; no done pulse.
//   - tx_start_q <= tx_start every clk. Accept when IDLE && tx_start && !tx_start_q.
//     A held-high tx_start never retriggers; a rising edge while not IDLE is ignored.
//   - FSM, tick counter t counts s_tick pulses only:
//     IDLE : tx=1. On accept -> START, t=0, busy=1.
//     START: tx=0. At s_tick with t==OVERSAMPLE-1: load shift reg from din, n=0 -> DATA.
//            din is sampled here, OVERSAMPLE ticks after accept, not at accept: upstream
//            updates its data register one clk after raising tx_start.
//     DATA : tx=shift[0]. At t==OVERSAMPLE-1: shift right, n++; when
//            n==NBIT_DATA_LEN-1 -> PARITY (if enabled) else STOP.
//     PARITY (only with PARITY_EN): tx = XOR of captured byte. After OVERSAMPLE ticks -> STOP.
//     STOP : tx=1. At t==SB_TICK-1: tx_done_tick=1 for exactly that clk, busy=0 -> IDLE.
//   - A rising edge of tx_start in the same clk as tx_done_tick is ignored (state not IDLE).
//     The next frame needs tx_start low for at least one clk after the pulse.
//   - t wraps to 0 on every bit boundary. n is clog2(NBIT_DATA_LEN) bits wide.
//   - tx is registered (no glitches). tx_done_tick is registered and held 0 outside STOP exit.
//   - s_tick low: counters hold; the frame stretches and its content is unchanged.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: even-parity bit inserted between the last data bit and stop;
//     frame = 1+NBIT_DATA_LEN+1 bits x OVERSAMPLE ticks + SB_TICK.
//   undefined: no PARITY state; frame = 1+NBIT_DATA_LEN bits x OVERSAMPLE ticks + SB_TICK.
// STRUCTURE
//   - Shared package uart_pkg: state encodings (IDLE/START/DATA/PARITY/STOP, 3-bit),
//     OVERSAMPLE and SB_TICK defaults. These are shared with uart_rx and baud_rate_gen.
//   - No sub-module. s_tick comes from the existing baud_rate_gen instance shared with uart_rx.
// TESTING (bench drives s_tick=1 every clk unless noted)
//   1. reset, din=0x5A, tx_start 0->1 -> tx low 16 clk, then 0,1,0,1,1,0,1,0 each 16 clk,
//      high 16 clk; tx_done_tick one pulse at clk 160 after accept; busy low after it.
//   2. hold tx_start=1 for 400 clk after test 1 -> exactly one frame and one done pulse.
//   3. raise tx_start with din=0x00, change din to 0xC3 one clk later -> frame carries 0xC3.
//   4. tx_start pulse at clk 50 of an ongoing frame -> ignored, frame unchanged, one done pulse.
//   5. assert reset at clk 70 of frame 0xFF -> tx=1 and busy=0 immediately, no done pulse.
//      A new edge afterwards sends a clean frame.
//   6. UART_TX_PARITY_EN, din=0x07 -> parity bit 1, done at clk 176.
//      s_tick every 4th clk -> same frame, duration x4.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and timing defaults shared by uart_tx, uart_rx
// and baud_rate_gen.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_SB_TICK    = 16;

  function automatic int uart_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, paced by the oversampled s_tick.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (8E1).
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_IDLE   | line high, waiting for a rising edge on tx_start
//  ST_START  | start bit (low); din is captured as this bit ends
//  ST_DATA   | shifting out NBIT_DATA_LEN data bits, LSB first
//  ST_PARITY | even-parity bit of the captured byte (UART_TX_PARITY_EN)
//  ST_STOP   | stop bit(s) high for SB_TICK ticks, then done pulse
module uart_tx
  import uart_pkg::*;
#(
  parameter int NBIT_DATA_LEN = 8,
  parameter int SB_TICK       = UART_SB_TICK,
  parameter int OVERSAMPLE    = UART_OVERSAMPLE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_tick,
  input  logic                     tx_start,
  input  logic [NBIT_DATA_LEN-1:0] din,
  output logic                     tx,
  output logic                     tx_done_tick,
  output logic                     busy
);

  localparam int TW = (uart_max(OVERSAMPLE, SB_TICK) > 1) ?
                      $clog2(uart_max(OVERSAMPLE, SB_TICK)) : 1;
  localparam int NW = (NBIT_DATA_LEN > 1) ? $clog2(NBIT_DATA_LEN) : 1;

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [NW-1:0] BIT_LAST = NW'(NBIT_DATA_LEN - 1);

  uart_state_e              state_q, state_d;
  logic [TW-1:0]            t_q, t_d;
  logic [NW-1:0]            n_q, n_d;
  logic [NBIT_DATA_LEN-1:0] shift_q, shift_d;
  logic                     tx_q, tx_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     tx_start_q;
  logic                     start_edge;
`ifdef UART_TX_PARITY_EN
  logic                     parity_q, parity_d;
`endif

  // Next-state, counters, shift register and the registered-output values.
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    n_d        = n_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    start_edge = tx_start && !tx_start_q;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_START;
          t_d     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (t_q == OS_LAST) begin
            // Upstream updates din one clk after raising tx_start, so the
            // byte is captured at the end of the start bit, not at accept.
            t_d      = '0;
            n_d      = '0;
            shift_d  = din;
`ifdef UART_TX_PARITY_EN
            parity_d = ^din;
`endif
            state_d  = ST_DATA;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (t_q == OS_LAST) begin
            t_d     = '0;
            shift_d = {1'b0, shift_q[NBIT_DATA_LEN-1:1]};
            n_d     = n_q + 1'b1;
            if (n_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (t_q == OS_LAST) begin
            t_d     = '0;
            state_d = ST_STOP;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (t_q == SB_LAST) begin
            t_d     = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase

    // Line level follows the state being entered so tx changes with state.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Single state register; reset aborts any frame without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      t_q        <= '0;
      n_q        <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      n_q        <= n_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven frame checks for uart_tx plus a hand-written
// mid-frame reset sequence. Honours UART_TX_PARITY_EN for the frame model.
module tb_uart_tx;

  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic       tx;
  logic       tx_done_tick;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] din0;        // din when tx_start rises
    logic [7:0] din1;        // din from one clk after the rise
    int         div;         // s_tick every div clocks
    int         glitch;      // extra tx_start pulse at this clk of the frame (0 = none)
    int         hold_extra;  // keep tx_start high this many clocks after the frame
    logic [7:0] exp_byte;    // byte the frame must carry
  } vec_t;

  vec_t vecs[6];

  uart_tx #(
    .NBIT_DATA_LEN(8),
    .SB_TICK(16),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_tick(s_tick),
    .tx_start(tx_start),
    .din(din),
    .tx(tx),
    .tx_done_tick(tx_done_tick),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line level for frame bit slot idx (0 = start bit).
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR && idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic run_frame(input vec_t v, input string tag);
    int   bit_clks;
    int   ndone;
    int   wave_err;
    int   done_cnt;
    int   done_at;
    int   extra_err;
    logic ex_tx;
    logic ex_busy;
    logic ex_done;
    bit_clks = OS * v.div;
    ndone    = bit_clks * NBITS;
    wave_err = 0;
    done_cnt = 0;
    done_at  = -1;

    @(negedge clk);
    tx_start = 1'b0;
    s_tick   = 1'b1;
    repeat (2) @(negedge clk);
    check($sformatf("%s_idle_tx", tag), tx, 1);
    check($sformatf("%s_idle_busy", tag), busy, 0);

    // Next posedge is the accept edge (clk 0 of the frame).
    din      = v.din0;
    tx_start = 1'b1;
    s_tick   = 1'b1;
    for (int j = 0; j <= ndone + 2; j++) begin
      @(negedge clk);
      ex_tx   = (j < ndone) ? exp_bit(v.exp_byte, j / bit_clks) : 1'b1;
      ex_busy = (j < ndone);
      ex_done = (j == ndone);
      if (tx !== ex_tx || busy !== ex_busy || tx_done_tick !== ex_done) wave_err++;
      if (tx_done_tick === 1'b1) begin
        done_cnt++;
        done_at = j;
      end
      if (j < ndone && (j % bit_clks) == bit_clks / 2)
        check($sformatf("%s_bit%0d", tag, j / bit_clks), tx, ex_tx);
      if (j == 0) din = v.din1;
      s_tick   = (((j + 1) % v.div) == 0);
      tx_start = (v.hold_extra > 0) || (j == 0) || (v.glitch != 0 && j + 1 == v.glitch);
    end
    check($sformatf("%s_wave_errs", tag), wave_err, 0);
    check($sformatf("%s_done_cnt", tag), done_cnt, 1);
    check($sformatf("%s_done_clk", tag), done_at, ndone);

    if (v.hold_extra > 0) begin
      extra_err = 0;
      s_tick = 1'b1;
      repeat (v.hold_extra) begin
        @(negedge clk);
        if (tx_done_tick !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) extra_err++;
      end
      check($sformatf("%s_held_start_no_retrigger", tag), extra_err, 0);
    end
    tx_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t clean;
    int   post_err;

    vecs[0] = '{8'h5A, 8'h5A, 1, 0,  400, 8'h5A};  // basic frame + held tx_start
    vecs[1] = '{8'h00, 8'hC3, 1, 0,  0,   8'hC3};  // din updated one clk late
    vecs[2] = '{8'hA5, 8'hA5, 1, 50, 0,   8'hA5};  // edge mid-frame ignored
    vecs[3] = '{8'h07, 8'h07, 1, 0,  0,   8'h07};  // parity bit 1 when enabled
    vecs[4] = '{8'h07, 8'h07, 4, 0,  0,   8'h07};  // s_tick every 4th clk
    vecs[5] = '{8'h80, 8'h80, 1, 0,  0,   8'h80};  // MSB-only byte

    reset    = 1'b1;
    tx_start = 1'b0;
    s_tick   = 1'b1;
    din      = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", tx_done_tick, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Mid-frame reset: abort at clk 70 of an 0xFF frame.
    @(negedge clk);
    tx_start = 1'b0;
    s_tick   = 1'b1;
    repeat (2) @(negedge clk);
    din      = 8'hFF;
    tx_start = 1'b1;
    repeat (71) @(negedge clk);
    check("rst_pre_busy", busy, 1);
    tx_start = 1'b0;
    reset    = 1'b1;
    #1;
    check("rst_tx_immediate", tx, 1);
    check("rst_busy_immediate", busy, 0);
    check("rst_done_immediate", tx_done_tick, 0);
    @(negedge clk);
    reset    = 1'b0;
    post_err = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_done_tick !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) post_err++;
    end
    check("rst_no_done_after", post_err, 0);

    clean = '{8'h3C, 8'h3C, 1, 0, 0, 8'h3C};
    run_frame(clean, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
